// File: rtl/readport_scan_pkg.sv
// ---------------------------------------------------------------------------
// readport_scan_pkg
//
// Shared definitions for the read-port scan sequencer:
//   - default array geometry (DEPTH entries of DATA_W bits)
//   - FSM state encodings, as legacy localparam constants plus a typed enum
//     that uses the same encodings
//   - next_idx(): modulo-DEPTH index increment used when stepping the scan
// ---------------------------------------------------------------------------
package readport_scan_pkg;

    localparam int DEFAULT_DEPTH  = 128;
    localparam int DEFAULT_DATA_W = 128;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        SEND  = ST_SEND,
        DONE  = ST_DONE
    } scan_state_e;

    // DEPTH is a power of two, so masking with DEPTH-1 gives the wrap.
    function automatic int unsigned next_idx(input int unsigned cur,
                                             input int unsigned depth);
        return (cur + 1) & (depth - 1);
    endfunction

endpackage

// File: rtl/readport_scan_ctrl.sv
// ---------------------------------------------------------------------------
// readport_scan_ctrl
//
// Walks a combinationally readable port array and streams entries out over
// a valid/ready interface, one beat per entry, tagged with index and last.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   start      one-cycle scan request, honoured only when idle
//   base_idx   first entry to read (sampled with start)
//   count      number of entries, 0..DEPTH (sampled with start)
//   arr_idx    index driven to the external array read mux
//   arr_data   combinational array entry at arr_idx
//   out_valid  beat available
//   out_ready  consumer accepts beat
//   out_data   registered entry
//   out_idx    index of out_data
//   out_last   final beat of the scan
//   busy       high whenever the FSM is not idle
//   done       one-cycle pulse at scan completion
//   csum       (only with READPORT_SCAN_CHECKSUM_EN) XOR of all accepted
//              beats of the current scan
//
// Configuration macro: READPORT_SCAN_CHECKSUM_EN adds the csum output.
// ---------------------------------------------------------------------------
module readport_scan_ctrl
    import readport_scan_pkg::*;
#(
    parameter  int DEPTH  = DEFAULT_DEPTH,
    parameter  int DATA_W = DEFAULT_DATA_W,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IDX_W-1:0]  base_idx,
    input  logic [IDX_W:0]    count,
    output logic [IDX_W-1:0]  arr_idx,
    input  logic [DATA_W-1:0] arr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef READPORT_SCAN_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);

    scan_state_e       state_q,     state_d;
    logic [IDX_W-1:0]  cur_q,       cur_d;
    logic [IDX_W:0]    rem_q,       rem_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [IDX_W-1:0]  out_idx_q,   out_idx_d;
    logic              out_last_q,  out_last_d;
`ifdef READPORT_SCAN_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q,      csum_d;
`endif

    logic handshake;

    // Only SEND ever has out_valid high, so this is a SEND-state acceptance.
    assign handshake = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
`ifdef READPORT_SCAN_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef READPORT_SCAN_CHECKSUM_EN
                    csum_d = '0;
`endif
                    if (count != '0) begin
                        cur_d   = base_idx;
                        rem_d   = count;
                        state_d = FETCH;
                    end else begin
                        // Empty scan: no beats, just the completion pulse.
                        state_d = DONE;
                    end
                end
            end

            FETCH: begin
                // arr_idx is already cur_q, so arr_data is the wanted entry.
                out_data_d  = arr_data;
                out_idx_d   = cur_q;
                out_last_d  = (rem_q == (IDX_W+1)'(1));
                out_valid_d = 1'b1;
                state_d     = SEND;
            end

            SEND: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
`ifdef READPORT_SCAN_CHECKSUM_EN
                    csum_d      = csum_q ^ out_data_q;
`endif
                    if (rem_q == (IDX_W+1)'(1)) begin
                        state_d = DONE;
                    end else begin
                        // cur only moves here, in the same edge that drops
                        // out_valid, so arr_idx never changes under a beat.
                        cur_d   = IDX_W'(next_idx(int'(cur_q), DEPTH));
                        rem_d   = rem_q - (IDX_W+1)'(1);
                        state_d = FETCH;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
`ifdef READPORT_SCAN_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
`ifdef READPORT_SCAN_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign arr_idx   = cur_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
`ifdef READPORT_SCAN_CHECKSUM_EN
    assign csum      = csum_q;
`endif

endmodule

// File: tb/tb_readport_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_readport_scan_ctrl
//
// Self-checking bench for readport_scan_ctrl (DEPTH=128, DATA_W=128).
// Table-driven scans with out_ready held high, plus hand-written sequences
// for back-pressure, start-while-busy, reset mid-scan and (with
// READPORT_SCAN_CHECKSUM_EN) the checksum output.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_readport_scan_ctrl;

    localparam int DEPTH  = 128;
    localparam int DATA_W = 128;
    localparam int IDX_W  = 7;

    localparam logic [127:0] ENTRY_BASE = 128'h0123_4567_89AB_CD00_FEDC_BA98_7654_3200;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [IDX_W-1:0]  base_idx;
    logic [IDX_W:0]    count;
    logic [IDX_W-1:0]  arr_idx;
    logic [DATA_W-1:0] arr_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              busy;
    logic              done;
`ifdef READPORT_SCAN_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int base;
        int cnt;
        int n_beats;
        int idx[4];
        int done_cyc;
    } vec_t;

    vec_t vecs[5];

    // Bench model of the array under test.
    function automatic logic [127:0] entry(input int i);
        logic [127:0] e;
        e = ENTRY_BASE | 128'(i) | (128'(i) << 64);
        return e;
    endfunction

    assign arr_data = entry(int'(arr_idx));

    always #5 clk = ~clk;

    readport_scan_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_idx  (base_idx),
        .count     (count),
        .arr_idx   (arr_idx),
        .arr_data  (arr_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef READPORT_SCAN_CHECKSUM_EN
        ,
        .csum      (csum)
`endif
    );

    // Advance to 1 ns after the next rising edge; inputs are driven and
    // outputs sampled there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Run one table entry with out_ready high and check every beat.
    task automatic applyStimulus(input vec_t v);
        int  beats;
        bit  seen_done;
        beats     = 0;
        seen_done = 0;
        out_ready = 1'b1;
        base_idx  = IDX_W'(v.base);
        count     = (IDX_W+1)'(v.cnt);
        start     = 1'b1;
        step();
        start     = 1'b0;
        for (int k = 0; k < 40 && !seen_done; k++) begin
            if (out_valid) begin
                if (beats == 0) checkOutput("first_valid_cycle", 128'(k), 128'd1);
                if (beats < 4) begin
                    checkOutput("beat_idx", 128'(out_idx), 128'(v.idx[beats]));
                    checkOutput("beat_data", out_data, entry(v.idx[beats]));
                    checkOutput("beat_last", 128'(out_last), 128'(beats == v.n_beats - 1));
                end
                beats++;
            end
            if (done) begin
                seen_done = 1;
                checkOutput("done_cycle", 128'(k), 128'(v.done_cyc));
                checkOutput("busy_at_done", 128'(busy), 128'd1);
            end
            if (!seen_done) step();
        end
        checkOutput("done_seen", 128'(seen_done), 128'd1);
        checkOutput("beat_count", 128'(beats), 128'(v.n_beats));
        step();
        checkOutput("done_one_cycle", 128'(done), 128'd0);
        checkOutput("idle_after_done", 128'(busy), 128'd0);
    endtask

    initial begin
        int  beats;
        bit  seen_done;
        bit  found;

        vecs[0] = '{base: 0,   cnt: 3, n_beats: 3, idx: '{0, 1, 2, 0},     done_cyc: 6};
        vecs[1] = '{base: 126, cnt: 4, n_beats: 4, idx: '{126, 127, 0, 1}, done_cyc: 8};
        vecs[2] = '{base: 9,   cnt: 0, n_beats: 0, idx: '{0, 0, 0, 0},     done_cyc: 0};
        vecs[3] = '{base: 50,  cnt: 1, n_beats: 1, idx: '{50, 0, 0, 0},    done_cyc: 2};
        vecs[4] = '{base: 127, cnt: 2, n_beats: 2, idx: '{127, 0, 0, 0},   done_cyc: 4};

        reset     = 1'b1;
        start     = 1'b0;
        base_idx  = '0;
        count     = '0;
        out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
        checkOutput("reset_busy",      128'(busy),      128'd0);
        checkOutput("reset_done",      128'(done),      128'd0);
        checkOutput("reset_arr_idx",   128'(arr_idx),   128'd0);
        checkOutput("reset_out_data",  out_data,        128'd0);
        checkOutput("reset_out_last",  128'(out_last),  128'd0);
        step();

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
            if (i == 0)
                checkOutput("last_data_literal", out_data,
                            128'h0123_4567_89AB_CD02_FEDC_BA98_7654_3202);
        end

        // Back-pressure on the first beat of base=5, count=2.
        out_ready = 1'b0;
        base_idx  = 7'd5;
        count     = 8'd2;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        checkOutput("stall_valid_first", 128'(out_valid), 128'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            checkOutput("stall_valid",   128'(out_valid), 128'd1);
            checkOutput("stall_idx",     128'(out_idx),   128'd5);
            checkOutput("stall_data",    out_data,        entry(5));
            checkOutput("stall_arr_idx", 128'(arr_idx),   128'd5);
        end
        out_ready = 1'b1;
        step();
        checkOutput("stall_drop_valid", 128'(out_valid), 128'd0);
        checkOutput("stall_next_arr",   128'(arr_idx),   128'd6);
        step();
        checkOutput("stall_b2_valid", 128'(out_valid), 128'd1);
        checkOutput("stall_b2_idx",   128'(out_idx),   128'd6);
        checkOutput("stall_b2_last",  128'(out_last),  128'd1);
        step();
        checkOutput("stall_done", 128'(done), 128'd1);
        step();
        checkOutput("stall_idle", 128'(busy), 128'd0);

        // Start pulses while busy must be ignored.
        out_ready = 1'b1;
        base_idx  = 7'd10;
        count     = 8'd3;
        start     = 1'b1;
        step();
        base_idx  = 7'd0;
        count     = 8'd5;
        beats     = 0;
        seen_done = 0;
        for (int k = 0; k < 40 && !seen_done; k++) begin
            if (k == 3) start = 1'b0;
            if (out_valid) begin
                if (beats < 3)
                    checkOutput("busy_start_idx", 128'(out_idx), 128'(10 + beats));
                beats++;
            end
            if (done) seen_done = 1;
            else step();
        end
        start = 1'b0;
        checkOutput("busy_start_done",  128'(seen_done), 128'd1);
        checkOutput("busy_start_beats", 128'(beats),     128'd3);
        step();
        checkOutput("busy_start_idle", 128'(busy), 128'd0);
        step();
        checkOutput("busy_start_no_restart", 128'(busy), 128'd0);

        // Reset while the second beat is being presented.
        base_idx = 7'd10;
        count    = 8'd3;
        start    = 1'b1;
        step();
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (out_valid && out_idx == 7'd11) found = 1;
            else step();
        end
        checkOutput("rst_second_beat_seen", 128'(found), 128'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
        checkOutput("rst_busy",      128'(busy),      128'd0);
        checkOutput("rst_done",      128'(done),      128'd0);
        checkOutput("rst_arr_idx",   128'(arr_idx),   128'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            checkOutput("rst_no_done", 128'(done), 128'd0);
            checkOutput("rst_stay_idle", 128'(busy), 128'd0);
        end

`ifdef READPORT_SCAN_CHECKSUM_EN
        // Checksum over entries 0 and 1.
        out_ready = 1'b1;
        base_idx  = 7'd0;
        count     = 8'd2;
        start     = 1'b1;
        step();
        start     = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 20 && !seen_done; k++) begin
            if (done) seen_done = 1;
            else step();
        end
        checkOutput("csum_done_seen", 128'(seen_done), 128'd1);
        checkOutput("csum_value", csum, 128'h0000_0000_0000_0001_0000_0000_0000_0001);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
